// File: rtl/mram_pkg.sv
// Shared types and constants for the MRAM access sequencer.
package mram_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RECOVER
  } state_e;

  // Pin vector order: {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}.
  localparam logic [4:0] PINS_INACTIVE = 5'b11111;
  localparam logic [1:0] BE_DEFAULT    = 2'b11;

  // A request with no byte selected means "whole word".
  function automatic logic [1:0] norm_be(input logic [1:0] be);
    return (be == 2'b00) ? BE_DEFAULT : be;
  endfunction

  function automatic logic [DATA_W-1:0] be_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mram_rr_arbiter.sv
// Two-way round-robin arbiter; grant is only consumed while the sequencer idles.
module mram_rr_arbiter
  import mram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid_i,
  input  logic       advance_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  logic last_grant_q;

  // Contested requests go to the requester that was not served last.
  always_comb begin
    grant_valid_o = |req_valid_i;
    if (&req_valid_i) grant_id_o = ~last_grant_q;
    else              grant_id_o = req_valid_i[1];
  end

  // Remember the most recent winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         last_grant_q <= 1'b1;
    else if (advance_i && grant_valid_o) last_grant_q <= grant_id_o;
  end

endmodule

// File: rtl/mram_access_sequencer.sv
// Shares the asynchronous MRAM port between two requesters and times the strobes.
module mram_access_sequencer
  import mram_pkg::*;
#(
  parameter int T_SETUP   = 1,
  parameter int T_ACCESS  = 4,
  parameter int T_RECOVER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [19:0] req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic [1:0]  req0_be,
  output logic        req0_ready,
  output logic        rsp0_valid,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [19:0] req1_addr,
  input  logic [15:0] req1_wdata,
  input  logic [1:0]  req1_be,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [15:0] rsp_rdata,
  output logic [19:0] addr_out,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic [15:0] parallel_data_in,
  output logic        chip_en,
  output logic        write_en,
  output logic        out_en,
  output logic        lower_byte_en,
  output logic        upper_byte_en
);

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD  = CNT_W'(T_ACCESS - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(T_RECOVER - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [1:0]          be_q;
  logic                gnt_q;
  logic [4:0]          pins_q;
  logic                data_oe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready0_q, ready1_q, rsp0_q, rsp1_q;

  logic                grant_valid, grant_id;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_be;

  mram_rr_arbiter u_arb (
    .clk          (clk),
    .rst_n        (rst),
    .req_valid_i  ({req1_valid, req0_valid}),
    .advance_i    (state_q == ST_IDLE),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  // Payload of whichever requester the arbiter picked.
  always_comb begin
    sel_write = grant_id ? req1_write : req0_write;
    sel_addr  = grant_id ? req1_addr  : req0_addr;
    sel_wdata = grant_id ? req1_wdata : req0_wdata;
    sel_be    = norm_be(grant_id ? req1_be : req0_be);
  end

  // Phase sequencer; every pin is set one cycle ahead for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      be_q      <= BE_DEFAULT;
      gnt_q     <= 1'b0;
      pins_q    <= PINS_INACTIVE;
      data_oe_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
    end else begin
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            state_q   <= ST_SETUP;
            cnt_q     <= SETUP_LD;
            wr_q      <= sel_write;
            be_q      <= sel_be;
            gnt_q     <= grant_id;
            addr_q    <= sel_addr;
            if (sel_write) wdata_q <= sel_wdata;
            data_oe_q <= sel_write;
            pins_q    <= {1'b0, 1'b1, 1'b1, ~sel_be[0], ~sel_be[1]};
            ready0_q  <= ~grant_id;
            ready1_q  <= grant_id;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q   <= ST_ACCESS;
            cnt_q     <= ACCESS_LD;
            pins_q[3] <= ~wr_q;
            pins_q[2] <= wr_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= ST_RECOVER;
            cnt_q   <= RECOVER_LD;
            pins_q  <= PINS_INACTIVE;
            if (!wr_q) rdata_q <= parallel_data_in & be_mask(be_q);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RECOVER: begin
          if (cnt_q == '0) begin
            state_q   <= ST_IDLE;
            data_oe_q <= 1'b0;
            rsp0_q    <= ~gnt_q;
            rsp1_q    <= gnt_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pins_q    <= PINS_INACTIVE;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign {chip_en, write_en, out_en, lower_byte_en, upper_byte_en} = pins_q;
  assign data_oe    = data_oe_q;
  assign addr_out   = addr_q;
  assign data_out   = wdata_q;
  assign rsp_rdata  = rdata_q;
  assign req0_ready = ready0_q;
  assign req1_ready = ready1_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;

endmodule

// File: tb/tb_mram_access_sequencer.sv
// Bench for mram_access_sequencer: default-timing and alternate-timing instances share stimulus.
module tb_mram_access_sequencer;

  localparam int CYC = 7;
  localparam logic [9:0] PINS_RST = 10'b1111100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0v, r0w, r1v, r1w;
  logic [19:0] r0a, r1a;
  logic [15:0] r0d, r1d;
  logic [1:0]  r0b, r1b;
  logic [15:0] pdata;

  logic        rdy0_a, rdy1_a, rsp0_a, rsp1_a, doe_a, ce_a, we_a, oe_a, lbe_a, ube_a;
  logic [15:0] rd_a, dout_a;
  logic [19:0] addr_a;
  logic        rdy0_b, rdy1_b, rsp0_b, rsp1_b, doe_b, ce_b, we_b, oe_b, lbe_b, ube_b;
  logic [15:0] rd_b, dout_b;
  logic [19:0] addr_b;

  mram_access_sequencer dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_write(r0w), .req0_addr(r0a), .req0_wdata(r0d), .req0_be(r0b),
    .req0_ready(rdy0_a), .rsp0_valid(rsp0_a),
    .req1_valid(r1v), .req1_write(r1w), .req1_addr(r1a), .req1_wdata(r1d), .req1_be(r1b),
    .req1_ready(rdy1_a), .rsp1_valid(rsp1_a),
    .rsp_rdata(rd_a), .addr_out(addr_a), .data_out(dout_a), .data_oe(doe_a),
    .parallel_data_in(pdata),
    .chip_en(ce_a), .write_en(we_a), .out_en(oe_a),
    .lower_byte_en(lbe_a), .upper_byte_en(ube_a)
  );

  mram_access_sequencer #(.T_SETUP(2), .T_ACCESS(1), .T_RECOVER(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_write(r0w), .req0_addr(r0a), .req0_wdata(r0d), .req0_be(r0b),
    .req0_ready(rdy0_b), .rsp0_valid(rsp0_b),
    .req1_valid(r1v), .req1_write(r1w), .req1_addr(r1a), .req1_wdata(r1d), .req1_be(r1b),
    .req1_ready(rdy1_b), .rsp1_valid(rsp1_b),
    .rsp_rdata(rd_b), .addr_out(addr_b), .data_out(dout_b), .data_oe(doe_b),
    .parallel_data_in(pdata),
    .chip_en(ce_b), .write_en(we_b), .out_en(oe_b),
    .lower_byte_en(lbe_b), .upper_byte_en(ube_b)
  );

  logic [9:0] pins_a, pins_b;
  assign pins_a = {ce_a, we_a, oe_a, lbe_a, ube_a, doe_a, rdy0_a, rdy1_a, rsp0_a, rsp1_a};
  assign pins_b = {ce_b, we_b, oe_b, lbe_b, ube_b, doe_b, rdy0_b, rdy1_b, rsp0_b, rsp1_b};

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [1:0]  be;
  } req_t;

  req_t q0[$], q1[$];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] defv(input logic [19:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mask_of(input logic [1:0] be);
    logic [1:0] e;
    e = (be == 2'b00) ? 2'b11 : be;
    return {{8{e[1]}}, {8{e[0]}}};
  endfunction

  // External memory seen through DUT A's pins, and the reference memory of the model.
  logic [15:0] mram [logic [19:0]];
  logic [15:0] refm [logic [19:0]];

  // Transaction-level model: who is served, when, and what a read must return.
  int          ecount = 0, e0 = 0;
  bit          active = 1'b0, last_g = 1'b1;
  bit          cur_g, cur_wr;
  logic [1:0]  cur_be;
  logic [19:0] cur_addr;
  logic [15:0] cur_wd, cur_rd;
  int          glog[$], elog[$];

  initial forever begin
    logic [15:0] old, m;
    @(posedge clk);
    ecount++;
    if (!rst) begin
      active = 1'b0;
      last_g = 1'b1;
    end else if ((!active || ecount >= e0 + CYC) && (r0v || r1v)) begin
      cur_g    = (r0v && r1v) ? !last_g : r1v;
      last_g   = cur_g;
      active   = 1'b1;
      e0       = ecount;
      cur_wr   = cur_g ? r1w : r0w;
      cur_addr = cur_g ? r1a : r0a;
      cur_wd   = cur_g ? r1d : r0d;
      cur_be   = cur_g ? r1b : r0b;
      m        = mask_of(cur_be);
      old      = refm.exists(cur_addr) ? refm[cur_addr] : defv(cur_addr);
      if (cur_wr) refm[cur_addr] = (old & ~m) | (cur_wd & m);
      else        cur_rd = old & m;
      glog.push_back(int'(cur_g));
      elog.push_back(ecount);
    end
  end

  // Expected pins for a cycle 'rel' cycles into a transaction (rel 0 = idle).
  function automatic logic [9:0] exp_pins(input int rel, input int ts, input int ta, input int tr);
    bit s, a, r, on, rsp;
    logic [1:0] e;
    s   = rel >= 1 && rel <= ts;
    a   = rel > ts && rel <= ts + ta;
    r   = rel > ts + ta && rel <= ts + ta + tr;
    on  = s || a;
    rsp = rel == ts + ta + tr + 1;
    e   = (cur_be == 2'b00) ? 2'b11 : cur_be;
    return {!on, !(a && cur_wr), !(a && !cur_wr), !(on && e[0]), !(on && e[1]),
            cur_wr && (s || a || r),
            rel == 1 && !cur_g, rel == 1 && cur_g, rsp && !cur_g, rsp && cur_g};
  endfunction

  task automatic check_one(input string nm, input int ts, input int ta, input int tr,
                           input logic [9:0] pins, input logic [19:0] ao,
                           input logic [15:0] dout, input logic [15:0] rd);
    int rel;
    if (!rst) begin
      chk({nm, ".rst_pins"}, 32'(pins), 32'(PINS_RST));
      chk({nm, ".rst_addr"}, 32'(ao), 32'h0);
      chk({nm, ".rst_rdata"}, 32'(rd), 32'h0);
    end else begin
      rel = active ? ecount - e0 + 1 : 0;
      if (rel > ts + ta + tr + 1) rel = 0;
      chk({nm, ".pins"}, 32'(pins), 32'(exp_pins(rel, ts, ta, tr)));
      if (rel >= 1 && rel <= ts + ta + tr) begin
        chk({nm, ".addr"}, 32'(ao), 32'(cur_addr));
        if (cur_wr) chk({nm, ".wdata"}, 32'(dout), 32'(cur_wd));
      end
      if (rel == ts + ta + tr + 1 && !cur_wr) chk({nm, ".rdata"}, 32'(rd), 32'(cur_rd));
    end
  endtask

  int cel_a, cel_b, wel_a, oel_a, lbl_a, ubl_a, lat0, rspcnt;
  logic [15:0] rd1;

  // Per-cycle comparison of both instances plus a few observation counters.
  initial forever begin
    @(negedge clk);
    check_one("A", 1, 4, 1, pins_a, addr_a, dout_a, rd_a);
    check_one("B", 2, 1, 3, pins_b, addr_b, dout_b, rd_b);
    if (!ce_a)  cel_a++;
    if (!ce_b)  cel_b++;
    if (!we_a)  wel_a++;
    if (!oe_a)  oel_a++;
    if (!lbe_a) lbl_a++;
    if (!ube_a) ubl_a++;
    if (rsp0_a) lat0 = ecount - e0 + 1;
    if (rsp1_a) rd1 = rd_a;
    if (rsp0_a || rsp1_a) rspcnt++;
  end

  // MRAM behaviour driven by DUT A's pins.
  initial forever begin
    logic [15:0] v;
    @(negedge clk);
    if (rst && !ce_a && !we_a) begin
      v = mram.exists(addr_a) ? mram[addr_a] : defv(addr_a);
      if (!lbe_a) v[7:0]  = dout_a[7:0];
      if (!ube_a) v[15:8] = dout_a[15:8];
      mram[addr_a] = v;
    end
    pdata = mram.exists(addr_a) ? mram[addr_a] : defv(addr_a);
  end

  task automatic drive();
    if (r0v && rdy0_a) void'(q0.pop_front());
    if (r1v && rdy1_a) void'(q1.pop_front());
    r0v = q0.size() != 0;
    if (r0v) {r0w, r0a, r0d, r0b} = q0[0];
    r1v = q1.size() != 0;
    if (r1v) {r1w, r1a, r1d, r1b} = q1[0];
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || r0v || r1v ||
            (active && ecount < e0 + CYC - 1)) && n < budget) begin
      step();
      n++;
    end
    step();
    chk("drain_left", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr   = 1'($urandom_range(0, 1));
    r.addr = 20'($urandom_range(0, 15));
    r.wd   = 16'($urandom);
    r.be   = 2'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    int n;
    rst = 1'b0;
    {r0v, r0w, r0a, r0d, r0b} = '0;
    {r1v, r1w, r1a, r1d, r1b} = '0;
    pdata = '0;
    repeat (3) step();
    chk("reset.pins_a", 32'(pins_a), 32'(PINS_RST));
    rst = 1'b1;
    step();

    // Single write from requester 0.
    {cel_a, cel_b, wel_a, lat0} = '0;
    q0.push_back('{1'b1, 20'h12345, 16'hBEEF, 2'b11});
    drain(40);
    chk("t1.lat", 32'(lat0), 32'd7);
    chk("t1.ce_a", 32'(cel_a), 32'd5);
    chk("t1.ce_b", 32'(cel_b), 32'd3);
    chk("t1.we_a", 32'(wel_a), 32'd4);
    chk("t1.mem", 32'(mram[20'h12345]), 32'h0000BEEF);

    // Lower-byte read from requester 1.
    mram[20'h00010] = 16'hA55A;
    refm[20'h00010] = 16'hA55A;
    oel_a = 0;
    q1.push_back('{1'b0, 20'h00010, 16'h0000, 2'b01});
    drain(40);
    chk("t2.oe_a", 32'(oel_a), 32'd4);
    chk("t2.rdata", 32'(rd1), 32'h0000005A);

    // Both requesters busy: grants alternate, one access every 7 cycles.
    glog.delete();
    elog.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b1, 20'(i + 1), 16'(16'h1100 + i), 2'b11});
      q1.push_back('{1'b1, 20'(i + 4), 16'(16'h2200 + i), 2'b11});
    end
    drain(100);
    chk("t3.count", 32'(glog.size()), 32'd6);
    for (int i = 0; i < glog.size() && i < 6; i++) begin
      chk("t3.grant", 32'(glog[i]), 32'(i % 2));
      if (i > 0) chk("t3.spacing", 32'(elog[i] - elog[i-1]), 32'd7);
    end

    // be 2'b00 selects both bytes.
    {lbl_a, ubl_a} = '0;
    q0.push_back('{1'b1, 20'h00002, 16'h1234, 2'b00});
    drain(40);
    chk("t4.lbe", 32'(lbl_a), 32'd5);
    chk("t4.ube", 32'(ubl_a), 32'd5);

    // Reset during the ACCESS phase of a write.
    q0.push_back('{1'b1, 20'hFFFFF, 16'hDEAD, 2'b11});
    n = 0;
    while (!(active && ecount - e0 + 1 == 3) && n < 20) begin
      step();
      n++;
    end
    chk("t5.reach_access", 32'(!we_a), 32'd1);
    rspcnt = 0;
    rst = 1'b0;
    #1;
    chk("t5.pins_a", 32'(pins_a), 32'(PINS_RST));
    chk("t5.pins_b", 32'(pins_b), 32'(PINS_RST));
    repeat (2) step();
    rst = 1'b1;
    repeat (8) step();
    chk("t5.no_rsp", 32'(rspcnt), 32'd0);
    rd1 = '0;
    q1.push_back('{1'b0, 20'h00010, 16'h0000, 2'b11});
    drain(40);
    chk("t5.fresh_rd", 32'(rd1), 32'h0000A55A);

    // Randomised traffic from both requesters.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back(rand_req());
      if ($urandom_range(0, 3) == 0 && q1.size() < 4) q1.push_back(rand_req());
      step();
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
